// File: rtl/pulse_timing_meas.sv
// pulse_timing_meas
//   Receive-side checker for the pulse generator. Samples the asynchronous
//   pulse and sync lines and measures one frame (sync rise to next sync rise).
//   Reports the first pulse width, the pulse1->pulse2 delay, the second pulse
//   width, the frame period and the pulse count over a valid/ready interface.
//
//   Ports
//     clk, resetn            clock, asynchronous active-low reset
//     enable                 high: measure continuously, low: abort to IDLE
//     pulse_in, sync_in      asynchronous lines under test
//     meas_valid/meas_ready  result handshake
//     width1, delay12,       time fields in clk cycles (CNT_W)
//     width2, period
//     n_pulses               rising pulse edges in the frame, saturating
//     overflow               frame timer saturated in this frame
//
//   Optional feature, macro BLOCK_CHECK_EN:
//     block_in   (in)        asynchronous blanking line
//     block_viol (out,CNT_W) frame cycles with pulse high while block is low
module pulse_timing_meas #(
  parameter int CNT_W       = 32,
  parameter int NPULSE_W    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                pulse_in,
  input  logic                sync_in,
  output logic                meas_valid,
  input  logic                meas_ready,
  output logic [CNT_W-1:0]    width1,
  output logic [CNT_W-1:0]    delay12,
  output logic [CNT_W-1:0]    width2,
  output logic [CNT_W-1:0]    period,
  output logic [NPULSE_W-1:0] n_pulses,
  output logic                overflow
`ifdef BLOCK_CHECK_EN
  ,
  input  logic                block_in,
  output logic [CNT_W-1:0]    block_viol
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, MEAS, DONE} state_t;

  localparam logic [CNT_W-1:0]    T_MAX = '1;
  localparam logic [NPULSE_W-1:0] N_MAX = '1;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sp, r_ss;
  logic                  r_p_d, r_s_d;
  logic [CNT_W-1:0]      r_timer, r_r1, r_f1, r_r2, r_f2;
  logic                  r_got_r1, r_got_f1, r_got_r2, r_got_f2, r_ovf;
  logic [NPULSE_W-1:0]   r_np;

  logic                  w_p, w_s, w_p_rise, w_p_fall, w_s_rise;
  logic [CNT_W-1:0]      w_tnow;

  // Every line sees the same synchronizer depth plus one edge flop, so
  // edge timings compare exactly in clk cycles.
  assign w_p      = r_sp[SYNC_STAGES-1];
  assign w_s      = r_ss[SYNC_STAGES-1];
  assign w_p_rise = w_p & ~r_p_d;
  assign w_p_fall = ~w_p & r_p_d;
  assign w_s_rise = w_s & ~r_s_d;
  // r_timer lags frame time by one cycle in MEAS; w_tnow is the frame time
  // of the current cycle, saturating.
  assign w_tnow   = (r_timer == T_MAX) ? T_MAX : r_timer + CNT_W'(1);

`ifdef BLOCK_CHECK_EN
  logic [SYNC_STAGES-1:0] r_sb;
  logic [CNT_W-1:0]       r_viol;
  logic                   w_viol;
  assign w_viol = w_p & ~r_sb[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_sp       <= '0;
      r_ss       <= '0;
      r_p_d      <= 1'b0;
      r_s_d      <= 1'b0;
      r_timer    <= '0;
      r_r1       <= '0;
      r_f1       <= '0;
      r_r2       <= '0;
      r_f2       <= '0;
      r_got_r1   <= 1'b0;
      r_got_f1   <= 1'b0;
      r_got_r2   <= 1'b0;
      r_got_f2   <= 1'b0;
      r_ovf      <= 1'b0;
      r_np       <= '0;
      meas_valid <= 1'b0;
      width1     <= '0;
      delay12    <= '0;
      width2     <= '0;
      period     <= '0;
      n_pulses   <= '0;
      overflow   <= 1'b0;
`ifdef BLOCK_CHECK_EN
      r_sb       <= '0;
      r_viol     <= '0;
      block_viol <= '0;
`endif
    end else begin
      r_sp  <= {r_sp[SYNC_STAGES-2:0], pulse_in};
      r_ss  <= {r_ss[SYNC_STAGES-2:0], sync_in};
      r_p_d <= w_p;
      r_s_d <= w_s;
`ifdef BLOCK_CHECK_EN
      r_sb  <= {r_sb[SYNC_STAGES-2:0], block_in};
`endif
      case (r_state)
        IDLE: if (enable) r_state <= WAIT_SYNC;

        WAIT_SYNC: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_s_rise) begin
            // Frame start is t=0; a pulse rise in this same cycle counts.
            r_state  <= MEAS;
            r_timer  <= '0;
            r_ovf    <= 1'b0;
            r_got_r1 <= w_p_rise;
            r_r1     <= '0;
            r_got_f1 <= 1'b0;
            r_got_r2 <= 1'b0;
            r_got_f2 <= 1'b0;
            r_np     <= w_p_rise ? NPULSE_W'(1) : '0;
`ifdef BLOCK_CHECK_EN
            r_viol   <= CNT_W'(w_viol);
`endif
          end
        end

        MEAS: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_s_rise) begin
            // Frame end: pulse edges in this cycle belong to no frame.
            r_state    <= DONE;
            meas_valid <= 1'b1;
            period     <= w_tnow;
            overflow   <= r_ovf;
            n_pulses   <= r_np;
            width1     <= r_got_f1 ? r_f1 - r_r1 : '0;
            delay12    <= r_got_r2 ? r_r2 - r_r1 : '0;
            width2     <= r_got_f2 ? r_f2 - r_r2 : '0;
`ifdef BLOCK_CHECK_EN
            block_viol <= r_viol;
`endif
          end else begin
            r_timer <= w_tnow;
            if (w_tnow == T_MAX) r_ovf <= 1'b1;
            if (w_p_rise) begin
              if (r_np != N_MAX) r_np <= r_np + NPULSE_W'(1);
              if (!r_got_r1) begin
                r_got_r1 <= 1'b1;
                r_r1     <= w_tnow;
              end else if (!r_got_r2) begin
                r_got_r2 <= 1'b1;
                r_r2     <= w_tnow;
              end
            end
            // A fall with no preceding rise in this frame is dropped.
            if (w_p_fall) begin
              if (r_got_r1 && !r_got_f1) begin
                r_got_f1 <= 1'b1;
                r_f1     <= w_tnow;
              end else if (r_got_r2 && !r_got_f2) begin
                r_got_f2 <= 1'b1;
                r_f2     <= w_tnow;
              end
            end
`ifdef BLOCK_CHECK_EN
            if (w_viol && r_viol != T_MAX) r_viol <= r_viol + CNT_W'(1);
`endif
          end
        end

        DONE: begin
          // Sync edges here are ignored; the next frame starts after handshake.
          if (meas_ready) begin
            meas_valid <= 1'b0;
            r_state    <= enable ? WAIT_SYNC : IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_timing_meas.sv
// tb_pulse_timing_meas
//   Directed bench for pulse_timing_meas. A 32-bit instance covers the main
//   measurement paths; an 8-bit-timer instance covers timer saturation.
//   Expected results are queued as frames are driven and popped on handshake.
module tb_pulse_timing_meas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, enable, en8, pulse, sync, ready, block;

  logic        meas_valid, overflow;
  logic [31:0] width1, delay12, width2, period;
  logic [7:0]  n_pulses;
  logic        v8, ovf8;
  logic [7:0]  w1_8, d12_8, w2_8, per_8, np_8;
`ifdef BLOCK_CHECK_EN
  logic [31:0] block_viol;
  logic [7:0]  bv8;
`endif

  pulse_timing_meas #(.CNT_W(32), .NPULSE_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pulse_in(pulse), .sync_in(sync),
    .meas_valid(meas_valid), .meas_ready(ready), .width1(width1), .delay12(delay12),
    .width2(width2), .period(period), .n_pulses(n_pulses), .overflow(overflow)
`ifdef BLOCK_CHECK_EN
    , .block_in(block), .block_viol(block_viol)
`endif
  );

  pulse_timing_meas #(.CNT_W(8), .NPULSE_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .resetn(resetn), .enable(en8), .pulse_in(pulse), .sync_in(sync),
    .meas_valid(v8), .meas_ready(ready), .width1(w1_8), .delay12(d12_8),
    .width2(w2_8), .period(per_8), .n_pulses(np_8), .overflow(ovf8)
`ifdef BLOCK_CHECK_EN
    , .block_in(block), .block_viol(bv8)
`endif
  );

  typedef struct {
    logic [31:0] w1, d12, w2, per;
    logic [7:0]  np;
    logic        ovf;
    logic [31:0] bv;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(int w1, int d12, int w2, int per, int np, int ovf, int bv);
    exp_t e;
    e.w1 = w1; e.d12 = d12; e.w2 = w2; e.per = per;
    e.np = np[7:0]; e.ovf = (ovf != 0); e.bv = bv;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: sync high for t<4, pulse high on [a0,a1) and [a2,a3),
  // block high on [b0,b1). Each step is driven 1 time unit after posedge.
  task automatic run_frame(input int per, input int a0, input int a1, input int a2,
                           input int a3, input int b0 = -1, input int b1 = -1);
    for (int t = 0; t < per; t++) begin
      @(posedge clk); #1;
      sync  = (t < 4);
      pulse = ((t >= a0) && (t < a1)) || ((t >= a2) && (t < a3));
      block = (t >= b0) && (t < b1);
    end
  endtask

  task automatic close_frame();
    run_frame(20, -1, -1, -1, -1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nvalid;

  initial begin
    resetn = 1'b0; enable = 1'b1; en8 = 1'b0; ready = 1'b1;
    pulse = 1'b0; sync = 1'b0; block = 1'b0;

    fork
      forever begin : mon32
        exp_t e;
        @(negedge clk);
        if (meas_valid && ready) begin
          chk("res32_expected", q32.size() > 0, 1);
          if (q32.size() > 0) begin
            e = q32.pop_front();
            chk("width1", width1, e.w1);
            chk("delay12", delay12, e.d12);
            chk("width2", width2, e.w2);
            chk("period", period, e.per);
            chk("n_pulses", n_pulses, e.np);
            chk("overflow", overflow, e.ovf);
`ifdef BLOCK_CHECK_EN
            chk("block_viol", block_viol, e.bv);
`endif
          end
        end
      end
      forever begin : mon8
        exp_t e8;
        @(negedge clk);
        if (v8 && ready) begin
          chk("res8_expected", q8.size() > 0, 1);
          if (q8.size() > 0) begin
            e8 = q8.pop_front();
            chk("w1_8", w1_8, e8.w1);
            chk("d12_8", d12_8, e8.d12);
            chk("w2_8", w2_8, e8.w2);
            chk("per_8", per_8, e8.per);
            chk("np_8", np_8, e8.np);
            chk("ovf_8", ovf8, e8.ovf);
`ifdef BLOCK_CHECK_EN
            chk("bv_8", bv8, e8.bv);
`endif
          end
        end
      end
    join_none

    // Reset state, then 500 idle cycles with enable high and no sync.
    cycles(3);
    chk("rst_valid", meas_valid, 0);
    chk("rst_width1", width1, 0);
    chk("rst_period", period, 0);
    chk("rst_npulses", n_pulses, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    nvalid = 0;
    repeat (500) begin
      @(negedge clk);
      if (meas_valid) nvalid++;
    end
    chk("idle_no_result", nvalid, 0);
    chk("idle_width1", width1, 0);

    // Two-pulse frame with ready held high.
    cycles(1);
    q32.push_back(mk(5, 20, 20, 1000, 2, 0, 25));
    run_frame(1000, 10, 15, 30, 50);
    close_frame();

    // Result held while ready is low for three further frames.
    ready = 1'b0;
    q32.push_back(mk(5, 20, 20, 1000, 2, 0, 25));
    run_frame(1000, 10, 15, 30, 50);
    for (int k = 0; k < 3; k++) begin
      run_frame(1000, 100, 103, 200, 210);
      chk("hold_valid", meas_valid, 1);
      chk("hold_width1", width1, 5);
      chk("hold_delay12", delay12, 20);
      chk("hold_width2", width2, 20);
      chk("hold_period", period, 1000);
    end
    ready = 1'b1;
    cycles(2);
    chk("after_ack_valid", meas_valid, 0);
    q32.push_back(mk(6, 20, 5, 1000, 2, 0, 11));
    run_frame(1000, 20, 26, 40, 45);
    close_frame();

    // Single pulse rising with the frame sync; pulses spanning the end.
    q32.push_back(mk(8, 0, 0, 200, 1, 0, 8));
    run_frame(200, 0, 8, -1, -1);
    close_frame();
    q32.push_back(mk(0, 0, 0, 200, 1, 0, 150));
    run_frame(200, 50, 250, -1, -1);
    close_frame();
    q32.push_back(mk(10, 140, 0, 200, 2, 0, 60));
    run_frame(200, 10, 20, 150, 300);
    close_frame();

    // 8-bit timer saturates: period and late captures clamp to 255.
    enable = 1'b0; en8 = 1'b1;
    cycles(3);
    q8.push_back(mk(5, 245, 0, 255, 2, 1, 15));
    run_frame(400, 10, 15, 300, 310);
    close_frame();
    cycles(2);
    en8 = 1'b0;

    // Enable dropped mid-frame: no result for the aborted frame.
    enable = 1'b1;
    cycles(3);
    run_frame(100, 10, 15, -1, -1);
    enable = 1'b0;
    cycles(3);
    chk("abort_valid", meas_valid, 0);
    enable = 1'b1;
    cycles(3);
    q32.push_back(mk(4, 7, 1, 150, 2, 0, 5));
    run_frame(150, 5, 9, 12, 13);
    close_frame();

    // Reset while a result is pending clears the outputs asynchronously.
    ready = 1'b0;
    run_frame(100, 10, 15, -1, -1);
    run_frame(30, -1, -1, -1, -1);
    chk("pre_rst_valid", meas_valid, 1);
    chk("pre_rst_width1", width1, 5);
    resetn = 1'b0;
    #2;
    chk("arst_valid", meas_valid, 0);
    chk("arst_width1", width1, 0);
    chk("arst_period", period, 0);
    chk("arst_npulses", n_pulses, 0);
    cycles(2);
    resetn = 1'b1; ready = 1'b1;
    cycles(3);
    // Reset in the middle of a frame; the next frame is measured cleanly.
    run_frame(60, 10, 15, -1, -1);
    resetn = 1'b0;
    #2;
    chk("mid_rst_valid", meas_valid, 0);
    cycles(2);
    resetn = 1'b1;
    cycles(3);
    q32.push_back(mk(1, 0, 0, 120, 1, 0, 1));
    run_frame(120, 3, 4, -1, -1);
    close_frame();

`ifdef BLOCK_CHECK_EN
    // Block high t=8..16, pulse t=10..19: only t=17..19 are violations.
    q32.push_back(mk(10, 0, 0, 100, 1, 0, 3));
    run_frame(100, 10, 20, -1, -1, 8, 17);
    close_frame();
`endif

    cycles(5);
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
